// File: rtl/leaf_out_packetizer_if.sv
// User-side streams, credit return and BFT output of the leaf packetizer.
// Master drives data/credits/ready; slave (the packetizer) drives acks, packet and error flag.
interface leaf_out_packetizer_if #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_OUT_PORTS = 2
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                 din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]                              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]                              ack_interface2user;
    logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg;
    logic                                                  credit_vld;
    logic [NUM_PORT_BITS-1:0]                              credit_port;
    logic                                                  out_ready;
    logic [PACKET_BITS-1:0]                                dout_leaf_interface2bft;
    logic                                                  credit_err;

    modport master (
        output din_leaf_user2interface, vld_user2interface, dest_cfg,
               credit_vld, credit_port, out_ready,
        input  ack_interface2user, dout_leaf_interface2bft, credit_err
    );

    modport slave (
        input  din_leaf_user2interface, vld_user2interface, dest_cfg,
               credit_vld, credit_port, out_ready,
        output ack_interface2user, dout_leaf_interface2bft, credit_err
    );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Round-robin credit-gated packetizer: one packet per cycle, 1-cycle latency from vld&ack to output.
// Output register holds while out_ready=0; acks are withheld until it drains.
module leaf_out_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input logic              clk,
    input logic              reset,
    leaf_out_packetizer_if.slave bus
);
    localparam int DEST_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CRED_BITS  = NUM_ADDR_BITS + 1;
    localparam int PTR_BITS   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CREDIT_MAX_I = 1 << NUM_ADDR_BITS;
    localparam logic [CRED_BITS-1:0] CREDIT_MAX = CRED_BITS'(CREDIT_MAX_I);

    logic [CRED_BITS-1:0]     credit     [NUM_OUT_PORTS];
    logic [CRED_BITS-1:0]     credit_nxt [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  payload    [NUM_OUT_PORTS];
    logic [DEST_BITS-1:0]     dest       [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] credit_ovf;
    logic [NUM_OUT_PORTS-1:0] ack;
    logic [PTR_BITS-1:0]      rr_ptr;
    logic [PTR_BITS-1:0]      grant_idx;
    logic                     grant_any;
    logic                     can_issue;
    logic                     credit_ok;
    logic                     credit_bad;
    logic [PACKET_BITS-1:0]   dout_q;
    logic                     err_q;

    assign credit_ok  = bus.credit_vld && (int'(bus.credit_port) < NUM_OUT_PORTS);
    assign credit_bad = bus.credit_vld && (int'(bus.credit_port) >= NUM_OUT_PORTS);
    assign can_issue  = !reset && (!dout_q[PACKET_BITS-1] || bus.out_ready);

    for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_port
        logic             inc;
        logic             dec;
        logic [CRED_BITS:0] sum;

        assign payload[g]  = bus.din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign dest[g]     = bus.dest_cfg[g*DEST_BITS +: DEST_BITS];
        assign eligible[g] = bus.vld_user2interface[g] && (credit[g] != '0);
        assign inc = credit_ok && (int'(bus.credit_port) == g);
        assign dec = grant_any && (int'(grant_idx) == g);
        // dec only happens with credit>0, so the sum never underflows
        assign sum = {1'b0, credit[g]}
                   + (inc ? (CRED_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0)
                   - (dec ? (CRED_BITS+1)'(1) : '0);
        assign credit_ovf[g] = sum > {1'b0, CREDIT_MAX};
        assign credit_nxt[g] = credit_ovf[g] ? CREDIT_MAX : sum[CRED_BITS-1:0];
    end

    always_comb begin
        logic [PTR_BITS-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            idx = PTR_BITS'((int'(rr_ptr) + k) % NUM_OUT_PORTS);
            if (!grant_any && can_issue && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        ack = '0;
        if (grant_any) begin
            ack[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            err_q  <= 1'b0;
            rr_ptr <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= CREDIT_MAX;
                addr[i]   <= '0;
            end
        end else begin
            if (grant_any) begin
                dout_q <= {1'b1, dest[grant_idx], addr[grant_idx], payload[grant_idx]};
                rr_ptr <= (int'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + PTR_BITS'(1);
            end else if (bus.out_ready) begin
                dout_q <= '0;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (grant_any && (int'(grant_idx) == i)) begin
                    addr[i] <= addr[i] + NUM_ADDR_BITS'(1);
                end
            end
            if (credit_bad || (|credit_ovf)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ack_interface2user      = ack;
    assign bus.dout_leaf_interface2bft = dout_q;
    assign bus.credit_err              = err_q;
endmodule
